// File: rtl/sram_bridge.sv
// sram_bridge: bridges the 32-bit processor data port onto a 16-bit synchronous SRAM.
// Each word access becomes two halfword SRAM cycles, low half first. The processor sees
// a busy flag and a one-cycle ready pulse per access. Every output is decoded from the
// registered state and the latched request, never from the live request inputs.
module sram_bridge #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORD_ADDR_WIDTH = 9,
  parameter int unsigned SRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  // Processor data port
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [WORD_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  input  logic [3:0]                 data_be,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       data_ready,
  output logic                       busy,
  output logic                       err_overrun,
  // SRAM port, strobes active low
  output logic                       sram_ce_n,
  output logic                       sram_we_n,
  output logic                       sram_oe_n,
  output logic                       sram_ub_n,
  output logic                       sram_lb_n,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]                sram_wr_data,
  input  logic [15:0]                sram_rd_data
);

  // FSM encoding
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAccLo  = 3'd1;
  localparam logic [2:0] StAccHi  = 3'd2;
  localparam logic [2:0] StRdTail = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic                       req;

  // Latched request fields
  logic                       op_wr_q;
  logic [WORD_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [3:0]                 be_q;

  // Read assembly and status
  logic [15:0]                lo_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic                       err_q;

  // Last driven SRAM address/data, held while the SRAM is idle
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;
  logic [15:0]                sram_wdata_q;

  assign req = data_wr_en | data_rd_en;

  // Next-state logic: fixed LO/HI sequence, reads take one extra tail cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req) state_d = StAccLo;
      StAccLo:  state_d = StAccHi;
      StAccHi:  state_d = op_wr_q ? StDone : StRdTail;
      StRdTail: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch; a write wins when both enables are set
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'h0;
    end else if (state_q == StIdle && req) begin
      op_wr_q <= data_wr_en;
      addr_q  <= data_addr;
      wdata_q <= data_write;
      be_q    <= data_be;
    end
  end

  // SRAM strobe and bus decode from state and latched request
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_ub_n    = 1'b1;
    sram_lb_n    = 1'b1;
    sram_addr    = sram_addr_q;
    sram_wr_data = sram_wdata_q;
    case (state_q)
      StAccLo: begin
        sram_ce_n    = 1'b0;
        sram_we_n    = ~op_wr_q;
        sram_oe_n    = op_wr_q;
        sram_lb_n    = ~be_q[0];
        sram_ub_n    = ~be_q[1];
        sram_addr    = {addr_q, 1'b0};
        sram_wr_data = wdata_q[15:0];
      end
      StAccHi: begin
        sram_ce_n    = 1'b0;
        sram_we_n    = ~op_wr_q;
        sram_oe_n    = op_wr_q;
        sram_lb_n    = ~be_q[2];
        sram_ub_n    = ~be_q[3];
        sram_addr    = {addr_q, 1'b1};
        sram_wr_data = wdata_q[DATA_WIDTH-1:16];
      end
      default: ;
    endcase
  end

  // Hold the last SRAM address/data so they do not toggle while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_q  <= '0;
      sram_wdata_q <= 16'h0;
    end else begin
      sram_addr_q  <= sram_addr;
      sram_wdata_q <= sram_wr_data;
    end
  end

  // Read capture: SRAM data lags its access cycle by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q    <= 16'h0;
      rdata_q <= '0;
    end else begin
      if (state_q == StAccHi && !op_wr_q) begin
        lo_q <= sram_rd_data;
      end
      // High half arrives in the tail cycle; publish the whole word on entry to DONE
      if (state_q == StRdTail) begin
        rdata_q <= {sram_rd_data, lo_q};
      end
    end
  end

  // Sticky overrun: any request while an access is in flight is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q != StIdle && req) begin
      err_q <= 1'b1;
    end
  end

  assign data_read   = rdata_q;
  assign data_ready  = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: randomized and directed stimulus for sram_bridge, checked every cycle
// against a word-level behavioural model, with an attached halfword SRAM model.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_rd_en, data_wr_en;
  logic [8:0]  data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_be;
  logic [31:0] data_read;
  logic        data_ready, busy, err_overrun;
  logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic [9:0]  sram_addr;
  logic [15:0] sram_wr_data;
  logic [15:0] sram_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_bridge #(
    .DATA_WIDTH     (32),
    .WORD_ADDR_WIDTH(9),
    .SRAM_ADDR_WIDTH(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_rd_en  (data_rd_en),
    .data_wr_en  (data_wr_en),
    .data_addr   (data_addr),
    .data_write  (data_write),
    .data_be     (data_be),
    .data_read   (data_read),
    .data_ready  (data_ready),
    .busy        (busy),
    .err_overrun (err_overrun),
    .sram_ce_n   (sram_ce_n),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n),
    .sram_addr   (sram_addr),
    .sram_wr_data(sram_wr_data),
    .sram_rd_data(sram_rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [15:0] init_hw(input logic [31:0] i);
    logic [31:0] w;
    w = init_word(i >> 1);
    return i[0] ? w[31:16] : w[15:0];
  endfunction

  // Halfword SRAM with byte strobes and one-cycle synchronous read
  logic [15:0] sram_mem [0:1023];
  bit          sram_init;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= init_hw(i);
      sram_init <= 1'b1;
    end else if (!sram_ce_n) begin
      if (!sram_we_n) begin
        if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_wr_data[7:0];
        if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_wr_data[15:8];
      end else if (!sram_oe_n) begin
        sram_rd_data <= sram_mem[sram_addr];
      end
    end
  end

  // Behavioural model: word memory plus a cycle count since acceptance.
  // Writes finish 3 cycles after acceptance, reads 4.
  logic [31:0] ref_mem [0:511];
  bit          m_init, m_seen;
  int          m_phase;
  logic        m_wr, m_err;
  logic [8:0]  m_addr;
  logic [31:0] m_data, m_rdata;
  logic [3:0]  m_be;
  logic [9:0]  m_saddr;
  logic [15:0] m_swd;

  always @(posedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      m_init = 1'b1;
    end
    if (rst) begin
      m_seen  = 1'b1;
      m_phase = 0;
      m_rdata = 32'h0;
      m_err   = 1'b0;
      m_saddr = 10'h0;
      m_swd   = 16'h0;
    end else if (m_seen) begin
      if (m_phase == 0) begin
        if (data_wr_en || data_rd_en) begin
          m_wr    = data_wr_en;
          m_addr  = data_addr;
          m_data  = data_write;
          m_be    = data_be;
          m_phase = 1;
        end
      end else begin
        if (data_wr_en || data_rd_en) m_err = 1'b1;
        m_phase = (m_phase == (m_wr ? 3 : 4)) ? 0 : m_phase + 1;
      end
      if (m_phase == 1) begin
        m_saddr = {m_addr, 1'b0};
        m_swd   = m_data[15:0];
        if (m_wr)
          for (int b = 0; b < 4; b++)
            if (m_be[b]) ref_mem[m_addr][8*b +: 8] = m_data[8*b +: 8];
      end
      if (m_phase == 2) begin
        m_saddr = {m_addr, 1'b1};
        m_swd   = m_data[31:16];
      end
      if (m_phase == 4) m_rdata = ref_mem[m_addr];
    end
  end

  // Every-cycle comparison against the model, sampled away from the active edge
  always @(negedge clk) begin
    if (m_seen) begin
      logic acc, hi;
      acc = (m_phase == 1) || (m_phase == 2);
      hi  = (m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("data_ready", data_ready, m_phase != 0 && m_phase == (m_wr ? 3 : 4));
      check("data_read", data_read, m_rdata);
      check("err_overrun", err_overrun, m_err);
      check("sram_ce_n", sram_ce_n, !acc);
      check("sram_we_n", sram_we_n, !(acc && m_wr));
      check("sram_oe_n", sram_oe_n, !(acc && !m_wr));
      check("sram_lb_n", sram_lb_n, !(acc && (hi ? m_be[2] : m_be[0])));
      check("sram_ub_n", sram_ub_n, !(acc && (hi ? m_be[3] : m_be[1])));
      check("sram_addr", sram_addr, m_saddr);
      check("sram_wr_data", sram_wr_data, m_swd);
    end
  end

  // One processor access; measures cycles from acceptance to the ready pulse
  task automatic do_req(input logic wr, input logic rd, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] be, input int exp_cyc,
                        input bit spur);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    data_wr_en = wr; data_rd_en = rd; data_addr = a; data_write = d; data_be = be;
    @(posedge clk); #1;
    data_wr_en = 1'b0; data_rd_en = 1'b0;
    data_addr = 9'($urandom); data_write = $urandom; data_be = 4'($urandom);
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (spur && cyc == 1) data_rd_en = 1'b1;
      if (spur && cyc == 2) data_rd_en = 1'b0;
      if (data_ready) break;
    end
    check("ready_latency", cyc, exp_cyc);
  endtask

  initial begin
    logic       w, r;
    logic [8:0] a;
    logic [3:0] be;
    rst = 1'b1; data_rd_en = 1'b0; data_wr_en = 1'b0;
    data_addr = '0; data_write = '0; data_be = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_data_read", data_read, 32'h0);
    check("reset_ce_n", sram_ce_n, 1'b1);
    check("reset_sram_addr", sram_addr, 10'h0);

    // Full write then read-back, then a write that must not disturb data_read
    do_req(1'b1, 1'b0, 9'h005, 32'hDEADBEEF, 4'hF, 3, 1'b0);
    check("wr_lo_halfword", sram_mem[10'h00A], 16'hBEEF);
    check("wr_hi_halfword", sram_mem[10'h00B], 16'hDEAD);
    do_req(1'b0, 1'b1, 9'h005, 32'h0, 4'hF, 4, 1'b0);
    check("read_back", data_read, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 9'h006, 32'h12345678, 4'hF, 3, 1'b0);
    check("read_held_over_write", data_read, 32'hDEADBEEF);

    // Partial write with be=0101
    do_req(1'b1, 1'b0, 9'h010, 32'h11223344, 4'hF, 3, 1'b0);
    do_req(1'b1, 1'b0, 9'h010, 32'hAABBCCDD, 4'b0101, 3, 1'b0);
    do_req(0, 1'b1, 9'h010, 32'h0, 4'hF, 4, 1'b0);
    check("partial_write", data_read, 32'h11BB33DD);

    // Overrun: write pulsed in the HI cycle of a read is dropped and flagged
    @(posedge clk); #1; data_rd_en = 1'b1; data_addr = 9'h020;
    @(posedge clk); #1; data_rd_en = 1'b0;
    @(posedge clk); #1; data_wr_en = 1'b1; data_write = 32'h0;
    @(posedge clk); #1; data_wr_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("overrun_set", err_overrun, 1'b1);
    check("overrun_no_write", {sram_mem[10'h041], sram_mem[10'h040]}, init_word(32'h20));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("overrun_cleared", err_overrun, 1'b0);

    // Reset while a read is in its HI cycle
    @(posedge clk); #1; data_rd_en = 1'b1; data_addr = 9'h005;
    @(posedge clk); #1; data_rd_en = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", data_ready, 1'b0);
    check("midreset_data_read", data_read, 32'h0);
    check("midreset_ce_n", sram_ce_n, 1'b1);
    do_req(1'b0, 1'b1, 9'h005, 32'h0, 4'hF, 4, 1'b0);
    check("read_after_reset", data_read, 32'hDEADBEEF);

    // Top address and simultaneous enables
    do_req(1'b1, 1'b0, 9'h1FF, 32'h0F0FF0F0, 4'hF, 3, 1'b0);
    check("top_hi_halfword", sram_mem[10'h3FF], 16'h0F0F);
    do_req(1'b0, 1'b1, 9'h1FF, 32'h0, 4'hF, 4, 1'b0);
    check("top_read_back", data_read, 32'h0F0FF0F0);
    do_req(1'b1, 1'b1, 9'h001, 32'hCAFEF00D, 4'hF, 3, 1'b0);
    do_req(1'b0, 1'b1, 9'h001, 32'h0, 4'hF, 4, 1'b0);
    check("both_enables_write", data_read, 32'hCAFEF00D);

    // Randomized traffic with occasional overruns and idle gaps
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      r = !w || ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       a = 9'h1FF;
        1:       a = 9'($urandom);
        default: a = 9'($urandom_range(0, 31));
      endcase
      be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      do_req(w, r, a, $urandom, be, w ? 3 : 4, $urandom_range(0, 15) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // SRAM contents must match the word model everywhere
    repeat (2) @(posedge clk);
    for (int i = 0; i < 512; i++) begin
      check("sram_contents", {sram_mem[2*i+1], sram_mem[2*i]}, ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
